// File: rtl/pe_conv_1x1_requant.sv
// 1x1 conv PE: LANES-wide MAC over IN_CHANNEL, requant (coeff, bias, round), out_valid 3 cycles after last beat.
// Input stalls (in_ready=0) while a result is pending; PE_RELU_EN selects ReLU/unsigned, else signed saturation.
module pe_conv_1x1_requant #(
  parameter int IN_CHANNEL = 20,
  parameter int LANES      = 8,
  parameter int COEFF_W    = 17,
  parameter int BIAS_W     = 32,
  parameter int FRAC       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   input_data,
  input  logic [8*LANES-1:0]   kernel_data,
  input  logic [COEFF_W-1:0]   coeff,
  input  logic [BIAS_W-1:0]    bias,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           output_data
);

  localparam int NUM_BEATS  = (IN_CHANNEL + LANES - 1) / LANES;
  localparam int ACC_W      = 17 + $clog2(IN_CHANNEL);
  localparam int PROD_W     = ACC_W + COEFF_W + 1;
  localparam int SUM_W      = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + 1;
  localparam int Q_W        = SUM_W - FRAC;
  localparam int LAST_LANES = IN_CHANNEL - (NUM_BEATS - 1) * LANES;
  localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(1) <<< (FRAC - 1);
  localparam logic signed [Q_W-1:0]   U_MAX = Q_W'(255);
  localparam logic signed [Q_W-1:0]   S_MAX = Q_W'(127);
  localparam logic signed [Q_W-1:0]   S_MIN = -(Q_W'(128));
  localparam logic signed [Q_W-1:0]   Q_ZERO = '0;

  typedef enum logic [1:0] {S_ACC, S_MUL, S_BIAS, S_OUT} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          beat_cnt;
  logic signed [ACC_W-1:0]   acc, partial;
  logic [COEFF_W-1:0]        coeff_q;
  logic signed [BIAS_W-1:0]  bias_q;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   sum;
  logic signed [Q_W-1:0]     q;
  logic [7:0]                q_clamped;
  logic                      last_beat;
  logic                      beat_acc;

  assign last_beat = (beat_cnt == CNT_W'(NUM_BEATS - 1));
  assign beat_acc  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_ACC: begin
        in_ready = rst_n;
        if (beat_acc && last_beat) state_nxt = S_MUL;
      end
      S_MUL:  state_nxt = S_BIAS;
      S_BIAS: state_nxt = S_OUT;
      S_OUT:  if (out_valid && out_ready) state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  // Lanes past the channel count on the final beat carry don't-care data.
  always_comb begin
    partial = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!last_beat || i < LAST_LANES)
        partial = partial + ACC_W'($signed({9'b0, input_data[8*i +: 8]}) *
                                   $signed({{9{kernel_data[8*i+7]}}, kernel_data[8*i +: 8]}));
    end
  end

  always_comb begin
    q         = sum[SUM_W-1:FRAC];
    q_clamped = q[7:0];
`ifdef PE_RELU_EN
    if (q < Q_ZERO)     q_clamped = 8'h00;
    else if (q > U_MAX) q_clamped = 8'hFF;
`else
    if (q < S_MIN)      q_clamped = 8'h80;
    else if (q > S_MAX) q_clamped = 8'h7F;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      acc         <= '0;
      coeff_q     <= '0;
      bias_q      <= '0;
      prod        <= '0;
      sum         <= '0;
      out_valid   <= 1'b0;
      output_data <= '0;
    end else begin
      if (beat_acc) begin
        if (beat_cnt == '0) begin
          acc     <= partial;
          coeff_q <= coeff;
          bias_q  <= $signed(bias);
        end else begin
          acc <= acc + partial;
        end
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end
      if (state == S_MUL)
        prod <= PROD_W'(acc) * PROD_W'($signed({1'b0, coeff_q}));
      if (state == S_BIAS)
        sum <= SUM_W'(prod) + SUM_W'(bias_q) + RND;
      // First S_OUT cycle loads the result; output then holds until taken.
      if (state == S_OUT) begin
        if (!out_valid) begin
          out_valid   <= 1'b1;
          output_data <= q_clamped;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_conv_1x1_requant.sv
// Directed table-driven bench for pe_conv_1x1_requant (IN_CHANNEL=20, LANES=8, three beats per pixel).
module tb_pe_conv_1x1_requant;

  localparam int IC = 20;
  localparam int LN = 8;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [8*LN-1:0] input_data;
  logic [8*LN-1:0] kernel_data;
  logic [16:0]   coeff;
  logic [31:0]   bias;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    output_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_conv_1x1_requant #(
    .IN_CHANNEL(IC), .LANES(LN), .COEFF_W(17), .BIAS_W(32), .FRAC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .kernel_data(kernel_data),
    .coeff(coeff), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_data(output_data)
  );

  typedef struct {
    logic [7:0]  act;
    logic [7:0]  wt;
    logic        ch0_only;
    logic [16:0] coeff;
    logic [31:0] bias;
    logic [7:0]  exp_relu;
    logic [7:0]  exp_sgn;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_of(input vec_t v);
`ifdef PE_RELU_EN
    return v.exp_relu;
`else
    return v.exp_sgn;
`endif
  endfunction

  // Channels beyond IC carry 0xFF/0x7F so any unmasked lane corrupts the sum.
  task automatic build_beat(input vec_t v, input int b, output logic [8*LN-1:0] a, output logic [8*LN-1:0] w);
    for (int l = 0; l < LN; l++) begin
      int ch;
      ch = b * LN + l;
      if (ch >= IC) begin
        a[8*l +: 8] = 8'hFF;
        w[8*l +: 8] = 8'h7F;
      end else if (v.ch0_only && ch != 0) begin
        a[8*l +: 8] = 8'h00;
        w[8*l +: 8] = 8'h00;
      end else begin
        a[8*l +: 8] = v.act;
        w[8*l +: 8] = v.wt;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input vec_t v, input int b, input string name);
    logic [8*LN-1:0] a, w;
    int guard;
    build_beat(v, b, a, w);
    input_data  = a;
    kernel_data = w;
    coeff       = v.coeff;
    bias        = v.bias;
    in_valid    = 1'b1;
    guard       = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk({name, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_pixel(input vec_t v, input string name);
    int lat;
    for (int b = 0; b < NB; b++) send_beat(v, b, name);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_data"}, 32'(output_data), 32'(exp_of(v)));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t va, vb, vx;

    vecs[0]  = '{8'd1,   8'd1,   1'b0, 17'h10000, 32'h0000_0000, 8'd20,  8'd20};
    vecs[1]  = '{8'd3,   8'd1,   1'b1, 17'h08000, 32'h0000_0000, 8'd2,   8'd2};
    vecs[2]  = '{8'd3,   8'd1,   1'b1, 17'h08000, 32'hFFFF_0000, 8'd1,   8'd1};
    vecs[3]  = '{8'd10,  8'hFF,  1'b0, 17'h10000, 32'h0000_0000, 8'h00,  8'h80};
    vecs[4]  = '{8'd255, 8'd127, 1'b0, 17'h10000, 32'h0000_0000, 8'hFF,  8'h7F};
    vecs[5]  = '{8'd2,   8'd2,   1'b0, 17'h10000, 32'h0000_0000, 8'd80,  8'd80};
    vecs[6]  = '{8'd5,   8'd3,   1'b0, 17'h04000, 32'h0000_0000, 8'd75,  8'd75};
    vecs[7]  = '{8'd0,   8'd0,   1'b0, 17'h10000, 32'h0005_8000, 8'd6,   8'd6};
    vecs[8]  = '{8'd0,   8'd0,   1'b0, 17'h10000, 32'hFFFA_8000, 8'h00,  8'hFB};
    vecs[9]  = '{8'd3,   8'hFF,  1'b0, 17'h10000, 32'h0000_0000, 8'h00,  8'hC4};
    vecs[10] = '{8'd1,   8'd1,   1'b0, 17'h1FFFF, 32'h0000_0000, 8'd40,  8'd40};
    vecs[11] = '{8'd200, 8'h80,  1'b0, 17'h10000, 32'h0000_0000, 8'h00,  8'h80};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    input_data  = '0;
    kernel_data = '0;
    coeff       = '0;
    bias        = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_output_data", 32'(output_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_pixel(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while next pixel's first beat waits.
    va = vecs[0];
    vb = vecs[5];
    for (int b = 0; b < NB; b++) send_beat(va, b, "bp_a");
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("bp_a_valid", 32'(out_valid), 32'd1);
    begin
      logic [8*LN-1:0] a, w;
      build_beat(vb, 0, a, w);
      input_data  = a;
      kernel_data = w;
      coeff       = vb.coeff;
      bias        = vb.bias;
      in_valid    = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_data%0d", k), 32'(output_data), 32'd20);
      chk($sformatf("bp_hold_in_ready%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    run_pixel(vb, "bp_b");

    // Reset mid-pixel: two beats of a large pattern, then reset.
    vx = '{8'd9, 8'd9, 1'b0, 17'h10000, 32'h0001_0000, 8'd0, 8'd0};
    send_beat(vx, 0, "rst_mid");
    send_beat(vx, 1, "rst_mid");
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_pixel(vecs[5], "rst_fresh");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
